// File: rtl/logic_unit_arbiter_if.sv
// Request/result bundle between client blocks and the shared logic unit arbiter.
// master = client side, slave = arbiter side.
interface logic_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     op_in;
  logic [WIDTH*N_REQ-1:0] a_in;
  logic [WIDTH*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [WIDTH-1:0]       result;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic                   op_err;

  modport master (
    output req, op_in, a_in, b_in,
    input  gnt, busy, result, res_valid, res_id, op_err
  );

  modport slave (
    input  req, op_in, a_in, b_in,
    output gnt, busy, result, res_valid, res_id, op_err
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR)
// among N_REQ requesters; one operation per IDLE->EXEC->DONE pass.
module logic_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic                 clk,
  input logic                 rst,
  logic_unit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  pick;
  logic             pick_valid;
  logic [ID_W:0]    sum;
  logic [N_REQ-1:0] gnt_nxt;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] alu;
  logic             alu_err;

  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q;
  logic             res_valid_q;
  logic [ID_W-1:0]  res_id_q;
  logic             op_err_q;

  logic [2:0]       op_arr [N_REQ];
  logic [WIDTH-1:0] a_arr  [N_REQ];
  logic [WIDTH-1:0] b_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g] = bus.op_in[3*g +: 3];
    assign a_arr[g]  = bus.a_in[WIDTH*g +: WIDTH];
    assign b_arr[g]  = bus.b_in[WIDTH*g +: WIDTH];
  end

  // Round-robin search: the index wraps by subtraction so non-power-of-two N_REQ works.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    sum        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ))
        sum = sum - (ID_W+1)'(N_REQ);
      if (!pick_valid && bus.req[sum[ID_W-1:0]]) begin
        pick       = sum[ID_W-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_nxt       = '0;
    gnt_nxt[pick] = 1'b1;
    ptr_nxt       = (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    alu     = '0;
    alu_err = 1'b0;
    unique case (op_t'(op_q))
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_NOTA: alu = ~a_q;
      OP_NAND: alu = ~(a_q & b_q);
      OP_NOR:  alu = ~(a_q | b_q);
      OP_XOR:  alu = a_q ^ b_q;
      OP_XNOR: alu = ~(a_q ^ b_q);
      OP_RSVD: alu_err = 1'b1;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      op_err_q    <= 1'b0;
      ptr         <= '0;
      winner      <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_q  <= gnt_nxt;
            winner <= pick;
            op_q   <= op_arr[pick];
            a_q    <= a_arr[pick];
            b_q    <= b_arr[pick];
            busy_q <= 1'b1;
          end
        end
        EXEC: begin
          result_q    <= alu;
          res_id_q    <= winner;
          op_err_q    <= alu_err;
          res_valid_q <= 1'b1;
          gnt_q       <= '0;
        end
        DONE: begin
          res_valid_q <= 1'b0;
          op_err_q    <= 1'b0;
          busy_q      <= 1'b0;
          ptr         <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (N_REQ=4, WIDTH=8).
module tb_logic_unit_arbiter;

  logic clk;
  logic rst;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_bad;

  logic_unit_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  logic_unit_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // gnt must never be multi-hot
  always @(negedge clk) if (!rst) check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_id", 32'(bus.res_id), 0);
    check("rst_op_err", 32'(bus.op_err), 0);
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.op_in[3*id +: 3] = op;
    bus.a_in[8*id +: 8]  = a;
    bus.b_in[8*id +: 8]  = b;
    bus.req[id]          = 1'b1;
  endtask

  task automatic wait_gnt(output int unsigned gcyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt == '0 && n < 8);
    check("gnt_seen", 32'(bus.gnt != '0), 1);
    gcyc = cyc;
  endtask

  task automatic expect_result(input int id, input logic [7:0] exp_res, input logic exp_err);
    check("res_valid", 32'(bus.res_valid), 1);
    check("result", 32'(bus.result), 32'(exp_res));
    check("res_id", 32'(bus.res_id), 32'(id));
    check("op_err", 32'(bus.op_err), 32'(exp_err));
    check("gnt_low_done", 32'(bus.gnt), 0);
  endtask

  task automatic run_op(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic exp_err, output int unsigned gcyc);
    logic [3:0] eg;
    eg = 4'b0001 << id;
    set_req(id, op, a, b);
    wait_gnt(gcyc);
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("busy_exec", 32'(bus.busy), 1);
    check("res_valid_exec", 32'(bus.res_valid), 0);
    bus.req[id] = 1'b0;
    tick();
    expect_result(id, exp_res, exp_err);
    tick();
    check("res_valid_drop", 32'(bus.res_valid), 0);
    check("busy_drop", 32'(bus.busy), 0);
  endtask

  logic [7:0] exp2 [7]   = '{8'hEE, 8'h33, 8'h77, 8'h11, 8'h66, 8'h99, 8'h00};
  logic [2:0] op3  [4]   = '{3'd0, 3'd1, 3'd5, 3'd4};
  logic [7:0] a3   [4]   = '{8'hF0, 8'h0F, 8'hAA, 8'h01};
  logic [7:0] b3   [4]   = '{8'h3C, 8'h30, 8'hFF, 8'h02};
  logic [7:0] r3   [4]   = '{8'h30, 8'h3F, 8'h55, 8'hFC};

  initial begin
    int unsigned g, gprev;
    logic [3:0] eg;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.req   = '0;
    bus.op_in = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;

    // Single AND on requester 0, with exact latency checks
    do_reset();
    set_req(0, 3'd0, 8'hCC, 8'hAA);
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_rv_early", 32'(bus.res_valid), 0);
    bus.req[0] = 1'b0;
    tick();
    expect_result(0, 8'h88, 1'b0);
    tick();
    check("t1_rv_drop", 32'(bus.res_valid), 0);
    check("t1_busy_drop", 32'(bus.busy), 0);
    tick();
    check("t1_result_held", 32'(bus.result), 32'h88);

    // Requester 2, opcodes 1..7, back to back
    gprev = 0;
    for (int i = 0; i < 7; i++) begin
      run_op(2, 3'(i + 1), 8'hCC, 8'hAA, exp2[i], (i == 6), g);
      if (i > 0) check("t2_gnt_spacing", g - gprev, 3);
      gprev = g;
    end

    // All four requesting continuously from reset
    for (int i = 0; i < 4; i++) begin
      bus.op_in[3*i +: 3] = op3[i];
      bus.a_in[8*i +: 8]  = a3[i];
      bus.b_in[8*i +: 8]  = b3[i];
    end
    bus.req = 4'b1111;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      eg = 4'b0001 << (k % 4);
      wait_gnt(g);
      check("t3_gnt_order", 32'(bus.gnt), 32'(eg));
      if (k > 0) check("t3_gnt_spacing", g - gprev, 3);
      gprev = g;
      tick();
      expect_result(k % 4, r3[k % 4], 1'b0);
      tick();
    end
    bus.req = '0;
    tick();

    // Pointer rotation: serve 1, then simultaneous 1 and 3
    do_reset();
    run_op(1, 3'd1, 8'h01, 8'h02, 8'h03, 1'b0, g);
    set_req(1, 3'd0, 8'hFF, 8'h0F);
    set_req(3, 3'd3, 8'hFF, 8'h0F);
    wait_gnt(g);
    check("t4_first_gnt", 32'(bus.gnt), 32'b1000);
    bus.req[3] = 1'b0;
    tick();
    expect_result(3, 8'hF0, 1'b0);
    wait_gnt(g);
    check("t4_second_gnt", 32'(bus.gnt), 32'b0010);
    bus.req[1] = 1'b0;
    tick();
    expect_result(1, 8'h0F, 1'b0);
    tick();

    // Reset during EXEC drops the operation and the pointer
    set_req(3, 3'd1, 8'h5A, 8'hA5);
    wait_gnt(g);
    check("t5_gnt3", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    rst = 1'b1;
    tick();
    check("t5_gnt", 32'(bus.gnt), 0);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_result", 32'(bus.result), 0);
    check("t5_res_valid", 32'(bus.res_valid), 0);
    check("t5_res_id", 32'(bus.res_id), 0);
    check("t5_op_err", 32'(bus.op_err), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_rv", 32'(bus.res_valid), 0);
    end
    set_req(0, 3'd5, 8'h0F, 8'h3C);
    set_req(3, 3'd0, 8'h0F, 8'h3C);
    wait_gnt(g);
    check("t5_gnt0_first", 32'(bus.gnt), 32'b0001);
    bus.req[0] = 1'b0;
    tick();
    expect_result(0, 8'h33, 1'b0);
    wait_gnt(g);
    check("t5_gnt3_next", 32'(bus.gnt), 32'b1000);
    bus.req[3] = 1'b0;
    tick();
    expect_result(3, 8'h0C, 1'b0);
    tick();

    // Input changes during EXEC are ignored
    set_req(0, 3'd0, 8'hCC, 8'hAA);
    wait_gnt(g);
    check("t6_gnt", 32'(bus.gnt), 32'b0001);
    bus.req[0]        = 1'b0;
    bus.op_in[2:0]    = 3'd1;
    bus.a_in[7:0]     = 8'h00;
    bus.b_in[7:0]     = 8'hFF;
    tick();
    expect_result(0, 8'h88, 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
